// File: rtl/fa16_adder_if.sv
// ---------------------------------------------------------------------------
// fa16_adder_if
//   Operand/result bundle for the fa16_adder ripple-carry adder.
//   Signals:
//     A  [WIDTH-1:0]  operand A, unsigned        (master -> slave)
//     B  [WIDTH-1:0]  operand B, unsigned        (master -> slave)
//     Ci              carry-in to bit 0          (master -> slave)
//     S  [WIDTH-1:0]  registered sum             (slave  -> master)
//     Co              registered carry-out       (slave  -> master)
//   Modports:
//     master : drives operands, observes results
//     slave  : the adder itself
// ---------------------------------------------------------------------------
interface fa16_adder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic [WIDTH-1:0] S;
  logic             Co;

  modport master (
    output A, B, Ci,
    input  S, Co
  );

  modport slave (
    input  A, B, Ci,
    output S, Co
  );
endinterface : fa16_adder_if

// File: rtl/fa16_adder.sv
// ---------------------------------------------------------------------------
// fa16_adder
//   WIDTH-bit ripple-carry adder, {Co,S} = A + B + Ci, with the sum and the
//   carry-out registered on clk. One-cycle latency, a new operand set every
//   cycle, no handshake.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous, active-high reset; clears S and Co
//     bus  fa16_adder_if slave modport (A, B, Ci in; S, Co out)
//
// fa_cell
//   Single-bit full adder used as the ripple-chain element.
//   Ports: a, b, ci in; s, co out.
// ---------------------------------------------------------------------------
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;            // propagate term, shared by sum and carry
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule : fa_cell

module fa16_adder #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  fa16_adder_if.slave  bus
);

  // carry[k] is the carry into cell k; carry[WIDTH] is the chain carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] s_q;
  logic             co_q;

  assign carry[0] = bus.Ci;

  // Plain ripple chain: each cell waits on its predecessor's carry, so the
  // worst-case path runs through all WIDTH cells within one clock period.
  for (genvar k = 0; k < WIDTH; k++) begin : g_chain
    fa_cell u_cell (
      .a  (bus.A[k]),
      .b  (bus.B[k]),
      .ci (carry[k]),
      .s  (sum_c[k]),
      .co (carry[k+1])
    );
  end

  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, so simulation matches the flops that get built.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= sum_c;
      co_q <= carry[WIDTH];
    end
  end

  assign bus.S  = s_q;
  assign bus.Co = co_q;

endmodule : fa16_adder

// File: tb/tb_fa16_adder.sv
// ---------------------------------------------------------------------------
// tb_fa16_adder
//   Directed vectors with hand-computed results, then a seeded random run
//   against {Co,S} = A + B + Ci with occasional reset pulses.
// ---------------------------------------------------------------------------
module tb_fa16_adder;

  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_mis;

  fa16_adder_if #(.WIDTH(WIDTH)) bus ();

  fa16_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH:0] got,
                       input logic [WIDTH:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got {Co,S}=%h expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge capture them and
  // compare the registered result 1 ns later.
  task automatic apply(input string tag, input logic r,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ci, input logic [WIDTH:0] exp);
    @(negedge clk);
    rst    = r;
    bus.A  = a;
    bus.B  = b;
    bus.Ci = ci;
    @(posedge clk);
    #1;
    check(tag, {bus.Co, bus.S}, exp);
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    logic             ci, r;
    logic [WIDTH:0]   exp;

    n_vec  = 0;
    n_mis  = 0;
    rst    = 1'b1;
    bus.A  = '0;
    bus.B  = '0;
    bus.Ci = 1'b0;

    // Reset dominates live operands for two edges, then first real sum.
    apply("rst_edge0", 1'b1, 16'h1234, 16'h1111, 1'b1, 17'h0_0000);
    apply("rst_edge1", 1'b1, 16'h1234, 16'h1111, 1'b1, 17'h0_0000);
    apply("rst_release", 1'b0, 16'h1234, 16'h1111, 1'b1, 17'h0_2346);

    // Inputs moving between edges must not disturb the registered result.
    #1;
    bus.A  = 16'hFFFF;
    bus.B  = 16'hFFFF;
    bus.Ci = 1'b1;
    #2;
    check("hold_between_edges", {bus.Co, bus.S}, 17'h0_2346);

    // Small-operand sweep: A=i, B=i+35, Ci=0 on every fourth step.
    for (int i = 0; i < 16; i++) begin
      ci  = (i % 4 == 0) ? 1'b0 : 1'b1;
      exp = 17'(2 * i + 35) + 17'(ci);
      apply($sformatf("sweep_%0d", i), 1'b0, 16'(i), 16'(i + 35), ci, exp);
    end

    // Full-length carry ripple and maximum operands.
    apply("ripple_ffff_p1",   1'b0, 16'hFFFF, 16'h0001, 1'b0, 17'h1_0000);
    apply("ripple_ffff_ci",   1'b0, 16'hFFFF, 16'h0000, 1'b1, 17'h1_0000);
    apply("max_ci1",          1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);
    apply("max_ci0",          1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 17'h1_FFFE);
    apply("zero_ci1",         1'b0, 16'h0000, 16'h0000, 1'b1, 17'h0_0001);
    apply("alt_bits",         1'b0, 16'hAAAA, 16'h5555, 1'b0, 17'h0_FFFF);

    // Back-to-back operand sets on consecutive edges.
    apply("b2b_8000_8000",    1'b0, 16'h8000, 16'h8000, 1'b0, 17'h1_0000);
    apply("b2b_7fff_1",       1'b0, 16'h7FFF, 16'h0001, 1'b0, 17'h0_8000);

    // Mid-stream reset discards the in-flight result.
    apply("midstream_rst",    1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h0_0000);
    apply("after_rst",        1'b0, 16'h0F0F, 16'h00F1, 1'b0, 17'h0_1000);

    // Random operands with sparse reset pulses.
    for (int n = 0; n < 10000; n++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      ci  = 1'($urandom);
      r   = ($urandom_range(0, 31) == 0);
      exp = r ? '0 : ({1'b0, a} + {1'b0, b} + {16'b0, ci});
      apply(r ? "rand_rst" : "rand_add", r, a, b, ci, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule : tb_fa16_adder

// File: doc/fa16_adder.md
Name: fa16_adder

Overview:
16-bit ripple-carry adder built from a chain of 1-bit full-adder cells. It computes S = A + B + Ci with carry-out Co. Sum and carry are registered on the system clock, with a synchronous active-high reset. It serves as a general arithmetic primitive in datapaths needing a plain binary add with carry-in/carry-out.

Parameters:
- WIDTH, 16, operand/sum width in bits; the chain length equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- Ci  input  1  carry-in to bit 0
- S  output  WIDTH  registered sum, bits [WIDTH-1:0] of A+B+Ci
- Co  output  1  registered carry-out of the MSB cell

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Structure: WIDTH full-adder cells in series.
  - Cell k: s_k = a_k ^ b_k ^ c_k; c_(k+1) = (a_k & b_k) | (c_k & (a_k ^ b_k)).
  - c_0 = Ci; Co source = c_WIDTH.
  - No carry-lookahead, carry-select or other acceleration.
  - The full-adder cell is a separate reusable submodule instantiated WIDTH times via generate.
- Arithmetic:
  - Unsigned modular add, {Co,S} = A + B + Ci (WIDTH+1-bit result).
  - No saturation and no overflow flag.
  - Signed interpretation is the caller's responsibility.
- Timing:
  - A, B and Ci are sampled at each rising clk edge.
  - S and Co reflect those operands after that edge: 1-cycle latency, fully pipelined, a new operand set is accepted every cycle.
  - No handshake; the output is valid every cycle after reset is released.
  - Input changes between edges have no effect on the outputs.
- Reset:
  - rst high at a rising edge forces S = 0 and Co = 0, whatever the inputs.
  - rst has priority over the add.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid sum appears at the first edge with rst low.
  - Output registers have no undefined state after the first reset edge.
- Boundary conditions:
  - All-ones + 1 wraps S to 0 with Co = 1.
  - All-ones + all-ones + Ci=1 gives S = all-ones, Co = 1.
  - Ci = 1 with A = B = 0 gives S = 1, Co = 0.
  - The carry must propagate through the full chain in one cycle; the clock period is constrained accordingly.

Test Plan:
- Reset: hold rst=1 for 2 edges with A=16'h1234, B=16'h1111, Ci=1 -> S=0, Co=0; release rst -> next edge S=16'h2346, Co=0.
- Sweep i=0..15, Ci=0 when i%4==0 else 1, A=i, B=i+35 -> one edge later S=A+B+Ci, Co=0 (e.g. i=0: S=35; i=1: S=38; i=15: S=66).
- Full carry ripple: A=16'hFFFF, B=16'h0001, Ci=0 -> S=16'h0000, Co=1; also A=16'hFFFF, B=0, Ci=1 -> S=0, Co=1.
- Max operands: A=16'hFFFF, B=16'hFFFF, Ci=1 -> S=16'hFFFF, Co=1; with Ci=0 -> S=16'hFFFE, Co=1.
- Back-to-back: apply a new operand pair every cycle (e.g. 16'h8000+16'h8000 then 16'h7FFF+1) -> results S=0/Co=1 then S=16'h8000/Co=0 on consecutive edges.
- Random: 10k random A, B, Ci compared against the reference model {Co,S}=A+B+Ci at 1-cycle latency, with rst pulsed randomly -> zero outputs on every reset edge, no mismatches otherwise.
